// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU datapath constants and register-file types.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_DATA_W = 64;
    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XZR_IDX    = 31;

    typedef logic [REG_ADDR_W-1:0]                  reg_addr_t;
    typedef logic [REG_DATA_W-1:0]                  reg_word_t;
    typedef logic [REG_NUM-1:0][REG_DATA_W-1:0]     reg_array_t;

endpackage
`default_nettype wire

// File: rtl/MUX_Nx32x1.sv
`default_nettype none
// ============================================================================
// Module      : MUX_Nx32x1
// Description : N-bit wide 32:1 multiplexer over a packed word array.
// Revision    : 1.0 - initial release
// ============================================================================
module MUX_Nx32x1 #(
    parameter int INPUT_LENGTH = 64
) (
    input  logic [31:0][INPUT_LENGTH-1:0] inputs_i,
    input  logic [4:0]                    sel_i,
    output logic [INPUT_LENGTH-1:0]       out_o
);

    // Pure combinational word select
    always_comb begin
        out_o = inputs_i[sel_i];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_decoder.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_decoder
// Description : Address to one-hot write-enable decode; zero register masked.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_decoder
    import cpu_pkg::*;
#(
    parameter int NUM_REGS   = REG_NUM,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int ZERO_REG   = NUM_REGS - 1
) (
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_REGS-1:0]   onehot_o
);

    // One-hot (or all-zero) decode; the zero register never gets an enable
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en_i && (addr_i == ADDR_WIDTH'(i)) && (i != ZERO_REG)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_32x64_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_32x64_2r1w
// Description : 32x64 architectural register file, two combinational read
//               ports, one synchronous write port, hardwired zero register
//               and optional same-cycle write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_32x64_2r1w
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int NUM_REGS   = REG_NUM,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int ZERO_REG   = NUM_REGS - 1,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                wr_en_i,
    input  logic [ADDR_WIDTH-1:0]               wr_addr_i,
    input  logic [DATA_WIDTH-1:0]               wr_data_i,
    input  logic [ADDR_WIDTH-1:0]               rd_addr_a_i,
    input  logic [ADDR_WIDTH-1:0]               rd_addr_b_i,
    output logic [DATA_WIDTH-1:0]               rd_data_a_o,
    output logic [DATA_WIDTH-1:0]               rd_data_b_o,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_o
);

    localparam logic [ADDR_WIDTH-1:0] c_zero_addr = ADDR_WIDTH'(ZERO_REG);

    logic [NUM_REGS-1:0]   w_wr_onehot;
    logic [DATA_WIDTH-1:0] w_mux_a;
    logic [DATA_WIDTH-1:0] w_mux_b;
    logic                  w_byp_a;
    logic                  w_byp_b;

    regfile_write_decoder #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_wr_dec (
        .en_i     (wr_en_i),
        .addr_i   (wr_addr_i),
        .onehot_o (w_wr_onehot)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            // Zero register has no storage; its decode bit is always 0
            logic w_unused_en;
            assign w_unused_en = w_wr_onehot[i];
            assign regs_o[i]   = '0;
        end else begin : g_flop
            logic [DATA_WIDTH-1:0] r_q;
            // Register storage: reset clears, otherwise load when selected
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    r_q <= '0;
                end else if (w_wr_onehot[i]) begin
                    r_q <= wr_data_i;
                end
            end
            assign regs_o[i] = r_q;
        end
    end

    MUX_Nx32x1 #(.INPUT_LENGTH(DATA_WIDTH)) u_mux_a (
        .inputs_i (regs_o),
        .sel_i    (rd_addr_a_i),
        .out_o    (w_mux_a)
    );

    MUX_Nx32x1 #(.INPUT_LENGTH(DATA_WIDTH)) u_mux_b (
        .inputs_i (regs_o),
        .sel_i    (rd_addr_b_i),
        .out_o    (w_mux_b)
    );

    // Forward in-flight write data to a matching read port (never during reset)
    always_comb begin
        w_byp_a = BYPASS_EN && wr_en_i && !reset_i &&
                  (wr_addr_i == rd_addr_a_i) && (wr_addr_i != c_zero_addr);
        w_byp_b = BYPASS_EN && wr_en_i && !reset_i &&
                  (wr_addr_i == rd_addr_b_i) && (wr_addr_i != c_zero_addr);
    end

    // Final per-port select: zero register first, then bypass, then storage
    always_comb begin
        if (rd_addr_a_i == c_zero_addr) begin
            rd_data_a_o = '0;
        end else if (w_byp_a) begin
            rd_data_a_o = wr_data_i;
        end else begin
            rd_data_a_o = w_mux_a;
        end

        if (rd_addr_b_i == c_zero_addr) begin
            rd_data_b_o = '0;
        end else if (w_byp_b) begin
            rd_data_b_o = wr_data_i;
        end else begin
            rd_data_b_o = w_mux_b;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_32x64_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_32x64_2r1w
// Description : Directed self-checking bench for regfile_32x64_2r1w; drives a
//               bypassing and a non-bypassing instance with shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_32x64_2r1w;

    logic                 clk;
    logic                 rst;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic [63:0]          wr_data;
    logic [4:0]           rd_a;
    logic [4:0]           rd_b;
    logic [63:0]          dat_a;
    logic [63:0]          dat_b;
    logic [31:0][63:0]    regs;
    logic [63:0]          dat_a_nb;
    logic [63:0]          dat_b_nb;
    logic [31:0][63:0]    regs_nb;

    logic [31:0][63:0]    m;
    int                   n_vec;
    int                   n_err;

    regfile_32x64_2r1w #(.BYPASS_EN(1'b1)) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_addr_a_i (rd_a),
        .rd_addr_b_i (rd_b),
        .rd_data_a_o (dat_a),
        .rd_data_b_o (dat_b),
        .regs_o      (regs)
    );

    regfile_32x64_2r1w #(.BYPASS_EN(1'b0)) dut_nb (
        .clk_i       (clk),
        .reset_i     (rst),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_addr_a_i (rd_a),
        .rd_addr_b_i (rd_b),
        .rd_data_a_o (dat_a_nb),
        .rd_data_b_o (dat_b_nb),
        .regs_o      (regs_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare both instances' register arrays against the bench model
    task automatic chk_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s_regs[%0d]", tag, i), regs[i], m[i]);
            chk($sformatf("%s_regs_nb[%0d]", tag, i), regs_nb[i], m[i]);
        end
    endtask

    // Advance one edge, leaving inputs stable until 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (a != 5'd31) m[a] = d;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m       = '0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_a    = '0;
        rd_b    = '0;
        tick();
        rst = 1'b0;

        // Reset: every register and both ports read zero
        chk_regs("reset");
        for (int i = 0; i < 32; i++) begin
            rd_a = 5'(i);
            rd_b = 5'(31 - i);
            #1;
            chk($sformatf("reset_rdA[%0d]", i), dat_a, 64'h0);
            chk($sformatf("reset_rdB[%0d]", 31 - i), dat_b, 64'h0);
        end

        // Write/readback
        wr(5'd5, 64'hDEAD_BEEF_0123_4567);
        wr(5'd17, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_a = 5'd5;
        rd_b = 5'd17;
        #1;
        chk("wr_rdA_x5", dat_a, 64'hDEAD_BEEF_0123_4567);
        chk("wr_rdB_x17", dat_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wr_nb_rdA_x5", dat_a_nb, 64'hDEAD_BEEF_0123_4567);
        chk_regs("wr");

        // Both ports on the same register
        rd_b = 5'd5;
        #1;
        chk("same_rdB_x5", dat_b, 64'hDEAD_BEEF_0123_4567);

        // XZR: write is dropped, bypass returns zero too
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = 64'hA5A5_A5A5_A5A5_A5A5;
        rd_a    = 5'd31;
        #1;
        chk("xzr_byp_rdA", dat_a, 64'h0);
        tick();
        wr_en = 1'b0;
        chk("xzr_rdA", dat_a, 64'h0);
        chk("xzr_nb_rdA", dat_a_nb, 64'h0);
        chk_regs("xzr");

        // Bypass versus non-bypass on X3
        wr(5'd3, 64'h1);
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 64'h2;
        rd_a    = 5'd3;
        rd_b    = 5'd3;
        #1;
        chk("byp_rdA", dat_a, 64'h2);
        chk("byp_rdB", dat_b, 64'h2);
        chk("nobyp_rdA", dat_a_nb, 64'h1);
        chk("nobyp_rdB", dat_b_nb, 64'h1);
        tick();
        wr_en = 1'b0;
        m[3]  = 64'h2;
        chk("post_byp_rdA", dat_a, 64'h2);
        chk("post_nobyp_rdA", dat_a_nb, 64'h2);
        chk("post_nobyp_rdB", dat_b_nb, 64'h2);

        // Write-enable gating on X9
        wr(5'd9, 64'h1234);
        wr_en   = 1'b0;
        wr_addr = 5'd9;
        wr_data = 64'h77;
        rd_a    = 5'd9;
        #1;
        chk("gate_pre_rdA", dat_a, 64'h1234);
        tick();
        chk("gate_rdA", dat_a, 64'h1234);
        wr_data = 'x;
        tick();
        chk("gate_x_rdA", dat_a, 64'h1234);
        chk("gate_x_nb_rdA", dat_a_nb, 64'h1234);
        chk_regs("gate");
        wr_data = '0;

        // Reset mid-operation discards a concurrent write
        for (int i = 1; i <= 30; i++) begin
            wr(5'(i), 64'(i));
        end
        chk_regs("preload");
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 64'h99;
        rd_a    = 5'd7;
        rd_b    = 5'd30;
        #1;
        chk("rst_nobyp_rdA", dat_a, 64'h7);
        chk("rst_rdB", dat_b, 64'h1E);
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        m     = '0;
        chk("rst_rdA_x7", dat_a, 64'h0);
        chk_regs("midrst");
        wr(5'd7, 64'h99);
        chk("after_rst_rdA", dat_a, 64'h99);
        chk("after_rst_nb_rdA", dat_a_nb, 64'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_32x64_2r1w.md
Name: regfile_32x64_2r1w

Overview:
- 32-entry x 64-bit architectural register file for the single-cycle/pipelined CPU datapath.
- Holds register state; its 32 register outputs feed the two read-port N-bit 32:1 multiplexer trees, which return Da/Db to decode/execute.
- One synchronous write port from write-back.
- Register 31 is the hardwired zero register (XZR).

Parameters:
- DATA_WIDTH, 64, bits per register.
- NUM_REGS, 32, register count; must be a power of two.
- ADDR_WIDTH, $clog2(NUM_REGS), register address width.
- ZERO_REG, NUM_REGS-1, index that always reads 0 and ignores writes.
- BYPASS_EN, 1, when 1 a same-cycle write is forwarded to a matching read.

Ports:
- clk_i  input  1  clock, rising-edge.
- reset_i  input  1  synchronous, active-high reset.
- wr_en_i  input  1  write enable.
- wr_addr_i  input  ADDR_WIDTH  write register index.
- wr_data_i  input  DATA_WIDTH  write data.
- rd_addr_a_i  input  ADDR_WIDTH  read port A index.
- rd_addr_b_i  input  ADDR_WIDTH  read port B index.
- rd_data_a_o  output  DATA_WIDTH  read port A data.
- rd_data_b_o  output  DATA_WIDTH  read port B data.
- regs_o  output  [NUM_REGS-1:0][DATA_WIDTH-1:0]  packed register array; same layout as the mux inputs_i, for mux and debug taps.

Behaviour:
- Storage: NUM_REGS x DATA_WIDTH flops, updated only on the rising edge of clk_i.
- Reset:
  - reset_i=1 at an edge clears all registers to 0. Reset overrides wr_en_i.
  - regs_o is all-zero from the cycle after the reset edge.
  - Reset asserted mid-program discards any write presented in that cycle.
- Write:
  - wr_en_i=1 and wr_addr_i!=ZERO_REG: reg[wr_addr_i] <= wr_data_i at the edge.
  - Exactly one register is written; the write-decode enable must be one-hot or zero.
  - wr_addr_i==ZERO_REG: write dropped, no state change.
  - wr_en_i=0: no state change regardless of address/data (X on data must not propagate).
- Read:
  - Combinational. Each port is an N-bit 32:1 selection over regs_o, indexed by rd_addr_x_i.
  - Zero latency from address change to data.
  - Reading ZERO_REG always returns 0, including in the bypass case.
  - Both ports may address the same register; both return identical data.
- Bypass (BYPASS_EN=1):
  - If wr_en_i=1, wr_addr_i==rd_addr_x_i and wr_addr_i!=ZERO_REG, then rd_data_x_o = wr_data_i in the same cycle, before the edge.
  - Applies independently per port.
  - Bypass is suppressed while reset_i=1; read returns current stored value.
- BYPASS_EN=0: reads return pre-edge stored value; the new value is visible the cycle after the write.
- Zero-register storage is tied to 0, not flops; regs_o[ZERO_REG] is constant 0.
- No internal FSM. Sequential state is the register array only. No stall/handshake; write-back guarantees at most one write per cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_DATA_W=64, REG_NUM=32, REG_ADDR_W=5, XZR_IDX=31.
  - typedef reg_addr_t (logic [4:0]).
  - typedef reg_word_t (logic [63:0]).
  - typedef reg_array_t (packed [31:0][63:0]).
- Sub-module: regfile_write_decoder (ADDR_WIDTH -> NUM_REGS one-hot with enable, ZERO_REG bit masked).
- Read ports instantiate the existing MUX_Nx32x1 twice (INPUT_LENGTH=DATA_WIDTH). Bypass and zero-forcing is a 2:1 select after each mux.

Test Plan:
- Reset then read all ports -> with reset_i=1 for 1 edge, every rd_addr 0..31 returns 64'h0 on both ports; regs_o == 0.
- Write/readback -> write X5=64'hDEAD_BEEF_0123_4567, X17=64'hFFFF_FFFF_FFFF_FFFF on consecutive cycles; read A=5, B=17 -> exact values; every other register still 0.
- XZR protection -> wr_en_i=1, wr_addr_i=31, wr_data_i=64'hA5A5_A5A5_A5A5_A5A5; next cycle rd A=31 -> 0; same cycle with BYPASS_EN=1 -> 0; no other register changed.
- Bypass -> BYPASS_EN=1, X3 holds 64'h1, write X3=64'h2 with rd A=3, B=3 in the same cycle -> both ports read 64'h2 before the edge. With BYPASS_EN=0 the same stimulus reads 64'h1, then 64'h2 the next cycle.
- Write-enable gating -> wr_en_i=0, wr_addr_i=9, wr_data_i=64'h77 (and a pass with wr_data_i=X) -> X9 stays at its prior value; no X on any output.
- Reset mid-operation -> preload X1..X30 with index values, assert reset_i together with a write X7=64'h99 -> after the edge all registers 0, X7 not 64'h99. Deassert, write X7=64'h99 -> reads 64'h99.
